dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store sequencer that sits directly upstream of the data memory.
- Accepts one core request at a time (byte/half/word, big endian) and drives the memory's r_w/mem_addr/mem_data.
- Captures the memory's registered read data; sign/zero-extends loads and does read-modify-write for sub-word stores, since the memory writes whole words only.
- Returns a single response per request.

Parameters:
- AW, 32, request/memory address width (only 32 supported).
- DW, 32, data width (only 32 supported).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1=store, 0=load.
- req_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-justified.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DW  extended load data; 0 for stores.
- rsp_err  out  1  misaligned request (feature-dependent).
- mem_r_w  out  1  to memory r_w; 1=write.
- mem_addr  out  AW  to memory mem_addr.
- mem_data  out  DW  to memory mem_data.
- mem_out  in  DW  from memory; valid the cycle after an address is presented with mem_r_w=0.

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_r_w=0; mem_addr=0; mem_data=0. An in-flight transaction is dropped; no write is issued after reset asserts.
- FSM states: IDLE, RD, CAP, WR, RESP. req_ready=1 only in IDLE.
- IDLE: on accept, latch we/size/addr/wdata. Next state is:
  - RD for a load or sub-word store;
  - WR for a word store;
  - RESP (rsp_err=1) for an error.
- RD: mem_addr={addr[31:2],2'b00}, mem_r_w=0. Next: CAP.
- CAP: mem_addr held, mem_r_w=0, mem_out sampled.
  - Load: rsp_rdata=extend(lane), go RESP.
  - Store: merged word registered, go WR.
- WR: mem_addr held, mem_r_w=1 for exactly one cycle, mem_data = wdata (word) or merged word. Next: RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready; then go IDLE. A new request is not accepted in the same cycle as the handshake.
- Big endian lanes:
  - Byte offset 0 = bits[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
  - Half offset 0 = [31:16], offset 2 = [15:0].
- Load extension: B/H sign-extend; BU/HU zero-extend; W passes through.
- Merge: only the addressed lane is replaced with wdata[7:0] (byte) or wdata[15:0] (half); other lanes keep the CAP-sampled value.
- Illegal req_size (011, 110, 111): rsp_err=1, no memory access, rsp_rdata=0.
- Latency, accept cycle = 0, to rsp_valid: load 3, word store 2, sub-word store 4, error 1.
- mem_addr/mem_data are 0 in IDLE and RESP; mem_r_w=0 everywhere except WR.
- rsp_rdata and rsp_err are cleared on entering IDLE.

Optional Feature:
- Macro: DMEM_LSU_MISALIGN_CHECK_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, gives rsp_err=1, no memory access, latency 1.
- Undefined: misalignment is not an error; H uses addr[1] only (addr[0] ignored); W ignores addr[1:0]. rsp_err is then set only for an illegal size.

Decomposition:
- Shared package dmem_lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_BU/SZ_HU;
  - state typedef/localparams for the five states;
  - LANE width constants.
- One sub-module: dmem_lsu_lane, combinational. Given offset and size, it extracts/extends load data and produces the merged store word. The FSM stays in the top.

Test Plan:
- Load path: memory word at 0x00000010 = 0x8A7F1234. LB addr 0x10 -> rsp_rdata 0xFFFFFF8A at cycle 3. LBU 0x11 -> 0x0000007F. LH 0x12 -> 0x00001234. LW 0x10 -> 0x8A7F1234.
- Sub-word store: SB 0x13 wdata 0xAB to word 0x8A7F1234 -> single WR cycle with mem_data 0x8A7F12AB at cycle 3, rsp_valid at cycle 4. Then LW 0x10 -> 0x8A7F12AB.
- Word and half stores: SW 0x20 wdata 0xDEADBEEF -> mem_r_w=1 at cycle 1 only, rsp at cycle 2. SH 0x22 wdata 0x5555 -> read back 0xDEAD5555.
- Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Second request is held off until one cycle after the handshake.
- Misalign/illegal: LW 0x21 with macro -> rsp_err=1 at cycle 1, no mem_r_w. Without macro -> returns word at 0x20. Size 011 -> rsp_err=1 in both builds.
- Reset mid-operation: assert reset during CAP of an SB -> mem_r_w never pulses, all outputs 0, req_ready=1 after release. Target word is unchanged.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the dmem_lsu load/store sequencer: size encodings,
// FSM states, lane widths and request-classification helpers.
package dmem_lsu_pkg;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int LANES  = DW / BYTE_W;

    // funct3-style access sizes
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } state_t;

    function automatic logic size_legal(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
               (size == SZ_BU) || (size == SZ_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        if ((size == SZ_H) || (size == SZ_HU)) bad = offset[0];
        else if (size == SZ_W)                 bad = (offset != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response bundle of dmem_lsu; the core is the master,
// the sequencer is the slave.
interface dmem_lsu_if;
    import dmem_lsu_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lsu_lane.sv
// Big-endian lane logic: extracts/extends the addressed lane of a memory word
// for loads and splices sub-word store data into that word.
module dmem_lsu_lane
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]        offset,
    input  logic [2:0]        size,
    input  logic [DW-1:0]     word,
    input  logic [HALF_W-1:0] wdata,
    output logic [DW-1:0]     load_data,
    output logic [DW-1:0]     merged
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    // Offset 0 is the most significant lane; halves only look at offset[1].
    always_comb begin
        case (offset)
            2'd0:    byte_lane = word[31:24];
            2'd1:    byte_lane = word[23:16];
            2'd2:    byte_lane = word[15:8];
            default: byte_lane = word[7:0];
        endcase
        half_lane = offset[1] ? word[15:0] : word[31:16];

        load_data = '0;
        merged    = word;
        case (size)
            SZ_B:  load_data = {{(DW-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
            SZ_BU: load_data = {{(DW-BYTE_W){1'b0}}, byte_lane};
            SZ_H:  load_data = {{(DW-HALF_W){half_lane[HALF_W-1]}}, half_lane};
            SZ_HU: load_data = {{(DW-HALF_W){1'b0}}, half_lane};
            SZ_W:  load_data = word;
            default: load_data = '0;
        endcase

        if ((size == SZ_B) || (size == SZ_BU)) begin
            case (offset)
                2'd0:    merged[31:24] = wdata[7:0];
                2'd1:    merged[23:16] = wdata[7:0];
                2'd2:    merged[15:8]  = wdata[7:0];
                default: merged[7:0]   = wdata[7:0];
            endcase
        end else if ((size == SZ_H) || (size == SZ_HU)) begin
            if (offset[1]) merged[15:0]  = wdata;
            else           merged[31:16] = wdata;
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer in front of a word-wide data memory with registered reads.
// Optional DMEM_LSU_MISALIGN_CHECK_EN turns misaligned H/HU/W accesses into errors.
module dmem_lsu
    import dmem_lsu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    dmem_lsu_if.slave     bus,
    output logic          mem_r_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_out
);

    state_t        state;
    logic          lat_we;
    logic [2:0]    lat_size;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] load_data;
    logic [DW-1:0] merged;
    logic          req_err;

    dmem_lsu_lane u_lane (
        .offset    (lat_addr[1:0]),
        .size      (lat_size),
        .word      (mem_out),
        .wdata     (lat_wdata[HALF_W-1:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
`ifdef DMEM_LSU_MISALIGN_CHECK_EN
        req_err = !size_legal(bus.req_size) || misaligned(bus.req_size, bus.req_addr[1:0]);
`else
        req_err = !size_legal(bus.req_size);
`endif
    end

    // Word stores skip the read; sub-word stores read, merge, then write back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            mem_r_w       <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
            lat_we        <= 1'b0;
            lat_size      <= '0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we        <= bus.req_we;
                        lat_size      <= bus.req_size;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (req_err) begin
                            state         <= ST_RESP;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                        end else if (bus.req_we && (bus.req_size == SZ_W)) begin
                            state    <= ST_WR;
                            mem_r_w  <= 1'b1;
                            mem_addr <= {bus.req_addr[AW-1:2], 2'b00};
                            mem_data <= bus.req_wdata;
                        end else begin
                            state    <= ST_RD;
                            mem_addr <= {bus.req_addr[AW-1:2], 2'b00};
                        end
                    end
                end
                ST_RD: state <= ST_CAP;
                ST_CAP: begin
                    if (lat_we) begin
                        state    <= ST_WR;
                        mem_r_w  <= 1'b1;
                        mem_data <= merged;
                    end else begin
                        state         <= ST_RESP;
                        mem_addr      <= '0;
                        bus.rsp_rdata <= load_data;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                ST_WR: begin
                    state         <= ST_RESP;
                    mem_r_w       <= 1'b0;
                    mem_addr      <= '0;
                    mem_data      <= '0;
                    bus.rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= ST_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: word memory with registered read, and a
// byte-addressed big-endian reference memory predicting every response.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_clear;
    logic        mem_r_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_out;
    logic [31:0] mem [0:63];
    logic [7:0]  ref_mem [0:255];
    int          total = 0;
    int          bad = 0;

    dmem_lsu_if bus ();

    dmem_lsu dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_r_w  (mem_r_w),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_out  (mem_out)
    );

    always #5 clk = ~clk;

    // Data memory: whole-word writes, read data registered one cycle later.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (mem_r_w) begin
            mem[mem_addr[7:2]] <= mem_data;
        end
        mem_out <= mem[mem_addr[7:2]];
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    function automatic int size_bytes(input logic [2:0] s);
        case (s)
            SZ_B, SZ_BU: return 1;
            SZ_H, SZ_HU: return 2;
            SZ_W:        return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic logic model_err(input logic [2:0] s, input int a);
        int n;
        n = size_bytes(s);
        if (n == 0) return 1'b1;
`ifdef DMEM_LSU_MISALIGN_CHECK_EN
        return (a % n) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] s, input int a);
        int     n;
        int     b;
        longint v;
        n = size_bytes(s);
        b = a - (a % n);
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | longint'(ref_mem[b + i]);
        if (((s == SZ_B) || (s == SZ_H)) && (v >= (longint'(1) << (8 * n - 1))))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] s, input int a, input logic [31:0] wdata);
        int n;
        int b;
        n = size_bytes(s);
        b = a - (a % n);
        for (int i = 0; i < n; i++) ref_mem[b + i] = 8'(wdata >> (8 * (n - 1 - i)));
    endtask

    function automatic logic [31:0] model_word(input int a);
        int          b;
        logic [31:0] w;
        b = a - (a % 4);
        w = '0;
        for (int i = 0; i < 4; i++) w = (w << 8) | {24'd0, ref_mem[b + i]};
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction: predict, drive, watch each cycle, hold, handshake.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        int          a;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
        int          exp_lat;
        int          exp_wr;
        int          lat;
        int          guard;
        int          wr_cnt;
        int          wr_cyc;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;

        a         = int'(addr[7:0]);
        exp_err   = model_err(size, a);
        exp_rdata = '0;
        exp_word  = '0;
        if (exp_err)           exp_lat = 1;
        else if (!we)          exp_lat = 3;
        else if (size == SZ_W) exp_lat = 2;
        else                   exp_lat = 4;
        exp_wr = (we && !exp_err) ? 1 : 0;
        if (!we && !exp_err) exp_rdata = model_load(size, a);
        if (exp_wr == 1) begin
            model_store(size, a, wdata);
            exp_word = model_word(a);
        end

        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);

        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;

        lat     = 1;
        wr_cnt  = 0;
        wr_cyc  = 0;
        wr_addr = '0;
        wr_data = '0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            if (mem_r_w === 1'b1) begin
                wr_cnt++;
                wr_cyc  = lat;
                wr_addr = mem_addr;
                wr_data = mem_data;
            end
            @(posedge clk); #1;
            lat++;
        end

        checkOutput({tag, ".latency"}, lat, exp_lat);
        checkOutput({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
        checkOutput({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_err));
        checkOutput({tag, ".writes"}, wr_cnt, exp_wr);
        checkOutput({tag, ".resp_mem_r_w"}, 32'(mem_r_w), 32'd0);
        checkOutput({tag, ".resp_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, ".resp_mem_data"}, mem_data, 32'd0);
        if (exp_wr == 1) begin
            checkOutput({tag, ".wr_cycle"}, wr_cyc, exp_lat - 1);
            checkOutput({tag, ".wr_addr"}, wr_addr, addr & 32'hFFFF_FFFC);
            checkOutput({tag, ".wr_data"}, wr_data, exp_word);
        end

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            checkOutput({tag, ".hold_rdata"}, bus.rsp_rdata, exp_rdata);
            checkOutput({tag, ".hold_err"}, 32'(bus.rsp_err), 32'(exp_err));
            checkOutput({tag, ".hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, ".post_valid"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, ".post_req_ready"}, 32'(bus.req_ready), 32'd1);
        checkOutput({tag, ".post_rdata"}, bus.rsp_rdata, 32'd0);
        checkOutput({tag, ".post_err"}, 32'(bus.rsp_err), 32'd0);
    endtask

    initial begin
        logic [2:0]  rsize;
        logic [31:0] raddr;
        logic        rwe;
        int          pick;
        int          guard;
        int          stray_writes;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        reset         = 1'b1;
        mem_clear     = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = SZ_W;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("reset.rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("reset.mem_r_w", 32'(mem_r_w), 32'd0);
        checkOutput("reset.mem_addr", mem_addr, 32'd0);
        checkOutput("reset.mem_data", mem_data, 32'd0);
        reset     = 1'b0;
        mem_clear = 1'b0;
        @(posedge clk); #1;

        applyStimulus("sw_init", 1'b1, SZ_W,  32'h10, 32'h8A7F1234, 0);
        applyStimulus("lb_10",   1'b0, SZ_B,  32'h10, 32'h0, 0);
        applyStimulus("lbu_11",  1'b0, SZ_BU, 32'h11, 32'h0, 0);
        applyStimulus("lh_12",   1'b0, SZ_H,  32'h12, 32'h0, 0);
        applyStimulus("lw_10",   1'b0, SZ_W,  32'h10, 32'h0, 0);
        applyStimulus("sb_13",   1'b1, SZ_B,  32'h13, 32'h000000AB, 0);
        applyStimulus("lw_10b",  1'b0, SZ_W,  32'h10, 32'h0, 0);
        applyStimulus("sw_20",   1'b1, SZ_W,  32'h20, 32'hDEADBEEF, 0);
        applyStimulus("sh_22",   1'b1, SZ_H,  32'h22, 32'h00005555, 0);
        applyStimulus("lw_20",   1'b0, SZ_W,  32'h20, 32'h0, 0);
        applyStimulus("lhu_20",  1'b0, SZ_HU, 32'h20, 32'h0, 0);
        applyStimulus("bp_lw",   1'b0, SZ_W,  32'h10, 32'h0, 5);
        applyStimulus("lw_21",   1'b0, SZ_W,  32'h21, 32'h0, 0);
        applyStimulus("lh_23",   1'b0, SZ_H,  32'h23, 32'h0, 0);
        applyStimulus("sz_011",  1'b0, 3'b011, 32'h20, 32'h0, 0);
        applyStimulus("sz_111s", 1'b1, 3'b111, 32'h20, 32'h12345678, 0);
        applyStimulus("lw_20c",  1'b0, SZ_W,  32'h20, 32'h0, 0);

        // Reset lands while the sub-word store is in its capture cycle.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_B;
        bus.req_addr  = 32'h13;
        bus.req_wdata = 32'h00000011;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        stray_writes  = (mem_r_w === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        if (mem_r_w === 1'b1) stray_writes++;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid.req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_mid.rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("rst_mid.mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mid.mem_data", mem_data, 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) reset = 1'b0;
            @(posedge clk); #1;
            if (mem_r_w === 1'b1) stray_writes++;
        end
        checkOutput("rst_mid.stray_writes", stray_writes, 0);
        checkOutput("rst_mid.req_ready_after", 32'(bus.req_ready), 32'd1);
        applyStimulus("rst_mid.lw_10", 1'b0, SZ_W, 32'h10, 32'h0, 0);

        for (int k = 0; k < 40; k++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                0, 1:    rsize = SZ_B;
                2:       rsize = SZ_BU;
                3, 4:    rsize = SZ_H;
                5:       rsize = SZ_HU;
                6, 7:    rsize = SZ_W;
                8:       rsize = 3'b011;
                default: rsize = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
            endcase
            rwe   = ($urandom_range(0, 1) == 1);
            raddr = 32'($urandom_range(0, 255));
            applyStimulus($sformatf("rand%0d", k), rwe, rsize, raddr, $urandom,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        guard = 0;
        for (int a = 0; a < 256; a += 4) begin
            applyStimulus($sformatf("sweep%0d", a), 1'b0, SZ_W, 32'(a), 32'h0, 0);
            guard++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
